coherent_avg_sequencer: RTL and testbench

COHERENT_AVG_SEQUENCER -- requirements
Module: coherent_avg_sequencer

---
 rtl/coherent_avg_pkg.sv | 23 ++
 rtl/wrap_counter.sv | 38 +++
 rtl/coherent_avg_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_coherent_avg_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherent_avg_pkg.sv
// coherent_avg_pkg
//   Shared definitions for the coherent averaging sequencer:
//   - seq_state_t : sequencer FSM states
//   - GAP_W       : width of the inter-frame gap length (used when SEQ_GAP_EN is defined)
//   - clog2_w     : index width for a counter of a given modulus (never below 1 bit)
package coherent_avg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  localparam int GAP_W = 8;

  // A modulus of 1 still needs a 1-bit index so port widths stay legal.
  function automatic int clog2_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
//   Modulo-MOD up-counter with a synchronous clear.
//   Ports:
//     clk     in   rising-edge clock
//     reset_n in   asynchronous active-low reset
//     inc     in   advance by one this cycle
//     clr     in   return to 0 this cycle (wins over inc)
//     count   out  current value, 0 .. MOD-1
//     wrap    out  inc while count == MOD-1, i.e. this cycle completes a period
module wrap_counter
  import coherent_avg_pkg::*;
#(
  parameter int MOD = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [clog2_w(MOD)-1:0] count,
  output logic                    wrap
);

  localparam int            CW   = clog2_w(MOD);
  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/coherent_avg_sequencer.sv
// coherent_avg_sequencer
//   Drives the enable of a table-based sample source so that whole signal
//   periods (M samples each) are acquired, and tags each returned beat with
//   its position in the period and its period number.
//
//   Optional feature: define SEQ_GAP_EN to add the gap_cycles input and the
//   GAP state (src_enable held low for gap_cycles cycles after every frame).
//
//   Ports:
//     clk         in   rising-edge clock
//     reset_n     in   asynchronous active-low reset (shared with the source)
//     start       in   begin a run (only honoured in IDLE)
//     stop_req    in   finish the run at the next frame boundary
//     n_frames    in   periods to acquire, captured at accepted start
//     gap_cycles  in   (SEQ_GAP_EN only) idle cycles after each frame, captured at start
//     src_valid   in   data_valid from the source
//     src_enable  out  registered enable to the source
//     busy        out  run in progress, up to and including the done cycle
//     done        out  one-cycle completion pulse
//     sample_idx  out  position of the current valid beat within its period
//     frame_idx   out  period number of the current valid beat (mod 2^NW)
//     sof, eof    out  first / last beat of a period is on src_valid
module coherent_avg_sequencer
  import coherent_avg_pkg::*;
#(
  parameter int M  = 32,
  parameter int NW = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop_req,
  input  logic [NW-1:0]         n_frames,
`ifdef SEQ_GAP_EN
  input  logic [GAP_W-1:0]      gap_cycles,
`endif
  input  logic                  src_valid,
  output logic                  src_enable,
  output logic                  busy,
  output logic                  done,
  output logic [clog2_w(M)-1:0] sample_idx,
  output logic [NW-1:0]         frame_idx,
  output logic                  sof,
  output logic                  eof
);

  localparam int             SIW    = clog2_w(M);
  localparam int             OW     = SIW + 1;
  localparam logic [SIW-1:0] LAST_S = SIW'(M - 1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             start_accepted;
  logic [SIW-1:0]   issue_idx;
  logic             issue_wrap;
  logic             beat_wrap;
  logic             stop_lat;
  logic             stop_seen;
  logic [NW-1:0]    frames_left;
  logic [OW-1:0]    outstanding;
  logic             drain_done;
  logic [GAP_W-1:0] gap_len;
`ifdef SEQ_GAP_EN
  logic [GAP_W-1:0] gap_cnt;
`endif

  assign start_accepted = (state == S_IDLE) && start;
  assign stop_seen      = stop_lat || stop_req;

  // Issue counter: counts enables so each frame is exactly M enables long.
  wrap_counter #(.MOD(M)) u_issue_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (src_enable),
    .clr     (start_accepted),
    .count   (issue_idx),
    .wrap    (issue_wrap)
  );

  // Valid-beat counter: follows the data actually returned by the source.
  wrap_counter #(.MOD(M)) u_beat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (src_valid),
    .clr     (start_accepted),
    .count   (sample_idx),
    .wrap    (beat_wrap)
  );

  assign sof = src_valid && (sample_idx == '0);
  assign eof = src_valid && (sample_idx == LAST_S);

  // The run may finish once no beat is still in flight from the source, or
  // the last in-flight beat (the final sample of the period) arrives now.
  // Requiring the issue counter at 0 guarantees only whole frames were issued.
  assign drain_done = (issue_idx == '0) &&
                      ((outstanding == '0) || (beat_wrap && outstanding == OW'(1)));

`ifdef SEQ_GAP_EN
  // Gap length is captured with the run so mid-run changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_len <= '0;
    end else if (start_accepted) begin
      gap_len <= gap_cycles;
    end
  end

  // Loaded with gap_len-1 on entry so GAP lasts exactly gap_len cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (state == S_RUN && issue_wrap && gap_len != '0) begin
      gap_cnt <= gap_len - GAP_W'(1);
    end else if (state == S_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end
`else
  assign gap_len = '0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (n_frames != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (issue_wrap) begin
          if (gap_len != '0) begin
            state_next = S_GAP;
          end else if (frames_left == NW'(1) || stop_seen) begin
            state_next = S_DRAIN;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_GAP: begin
`ifdef SEQ_GAP_EN
        // frames_left was already decremented at the wrap that entered GAP.
        if (gap_cnt == '0) begin
          state_next = (frames_left == '0 || stop_seen) ? S_DRAIN : S_RUN;
        end
`else
        state_next = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register; the outputs are registered from the next state so
  // src_enable rises on the edge that accepts start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      src_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      src_enable <= (state_next == S_RUN);
      busy       <= (state_next != S_IDLE);
      done       <= (state_next == S_DONE);
    end
  end

  // Frames still to issue; captured at start, counted down per issued frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_left <= '0;
    end else if (start_accepted) begin
      frames_left <= n_frames;
    end else if (issue_wrap) begin
      frames_left <= frames_left - NW'(1);
    end
  end

  // Stop latch: a stop arriving together with start is kept, so one frame runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_lat <= 1'b0;
    end else if (state == S_IDLE) begin
      stop_lat <= start && stop_req;
    end else if (state_next == S_IDLE) begin
      stop_lat <= 1'b0;
    end else if (stop_req) begin
      stop_lat <= 1'b1;
    end
  end

  // Beats requested from the source but not yet returned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (start_accepted) begin
      outstanding <= '0;
    end else begin
      case ({src_enable, src_valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= (outstanding != '0) ? outstanding - OW'(1) : outstanding;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Period number of returned data, advancing when a period completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_idx <= '0;
    end else if (start_accepted) begin
      frame_idx <= '0;
    end else if (beat_wrap) begin
      frame_idx <= frame_idx + NW'(1);
    end
  end

endmodule

// File: tb/tb_coherent_avg_sequencer.sv
// tb_coherent_avg_sequencer
//   Bench for coherent_avg_sequencer (M=32, NW=16). Contains a table source
//   (valid = enable delayed one cycle, table pointer advancing per enable)
//   and a per-cycle expectation model built from the frame/gap/stop rules.
//   Define SEQ_GAP_EN for both bench and RTL to exercise the gap feature.
module tb_coherent_avg_sequencer;

  localparam int M    = 32;
  localparam int NW   = 16;
  localparam int SIW  = 5;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop_req = 1'b0;
  logic [NW-1:0] n_frames = '0;
`ifdef SEQ_GAP_EN
  logic [7:0]    gap_cycles = '0;
`endif
  logic          src_valid;
  logic          src_enable;
  logic          busy;
  logic          done;
  logic [SIW-1:0] sample_idx;
  logic [NW-1:0] frame_idx;
  logic          sof;
  logic          eof;

  int src_ptr;
  int src_entry;

  int check_count = 0;
  int pass_count  = 0;

  // Expectation model, indexed by cycle relative to the start cycle.
  bit exp_en    [MAXC];
  bit exp_valid [MAXC];
  bit exp_busy  [MAXC];
  bit exp_done  [MAXC];
  int exp_beat  [MAXC];
  int run_len = 0;
  int cyc = 0;
  bit checking = 1'b0;

  // Observations accumulated over one run.
  int obs_en, obs_valid, obs_sof, obs_eof, obs_busy, obs_done_cyc, obs_max_frame;

  always #5 clk = ~clk;

  coherent_avg_sequencer #(.M(M), .NW(NW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop_req   (stop_req),
    .n_frames   (n_frames),
`ifdef SEQ_GAP_EN
    .gap_cycles (gap_cycles),
`endif
    .src_valid  (src_valid),
    .src_enable (src_enable),
    .busy       (busy),
    .done       (done),
    .sample_idx (sample_idx),
    .frame_idx  (frame_idx),
    .sof        (sof),
    .eof        (eof)
  );

  // Sample source: one-cycle enable->valid lag, table entry per enable.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_valid <= 1'b0;
      src_ptr   <= 0;
      src_entry <= 0;
    end else begin
      src_valid <= src_enable;
      if (src_enable) begin
        src_entry <= src_ptr;
        src_ptr   <= (src_ptr + 1) % M;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: actual %0d, required %0d",
               name, cyc, actual, expected);
    end
  endtask

  // Per-cycle compare of the DUT against the model.
  always @(negedge clk) begin
    if (checking && cyc < run_len) begin
      check_output("src_enable", 32'(src_enable), 32'(exp_en[cyc]));
      check_output("busy", 32'(busy), 32'(exp_busy[cyc]));
      check_output("done", 32'(done), 32'(exp_done[cyc]));
      check_output("src_valid", 32'(src_valid), 32'(exp_valid[cyc]));
      if (exp_valid[cyc]) begin
        check_output("sample_idx", 32'(sample_idx), exp_beat[cyc] % M);
        check_output("frame_idx", 32'(frame_idx), (exp_beat[cyc] / M) % (1 << NW));
        check_output("sof", 32'(sof), 32'(exp_beat[cyc] % M == 0));
        check_output("eof", 32'(eof), 32'(exp_beat[cyc] % M == M - 1));
        check_output("table_phase", 32'(sample_idx), src_entry);
      end else begin
        check_output("sof_quiet", 32'(sof), 0);
        check_output("eof_quiet", 32'(eof), 0);
      end
      obs_en    += int'(src_enable);
      obs_valid += int'(src_valid);
      obs_sof   += int'(sof);
      obs_eof   += int'(eof);
      obs_busy  += int'(busy);
      if (done) obs_done_cyc = cyc;
      if (src_valid && int'(frame_idx) > obs_max_frame) obs_max_frame = int'(frame_idx);
    end
  end

  // Runs one acquisition: builds the expected waveform from the run rules,
  // drives start at cycle 0, optional stop / re-start / n_frames change, and
  // optionally aborts with reset at cycle abort_c.
  task automatic apply_stimulus(input int n, input int g, input int stop_c,
                                input bit do_restart, input int abort_c);
    int geff, period, f_run, done_c, restart_c, nchange_c, c0, last_c;
`ifdef SEQ_GAP_EN
    geff = g;
`else
    geff = 0;
`endif
    period = M + geff;
    if (n == 0)           f_run = 0;
    else if (stop_c < 0)  f_run = n;
    else if (stop_c == 0) f_run = 1;
    else                  f_run = ((stop_c - 1) / period + 1 < n) ? (stop_c - 1) / period + 1 : n;

    for (int i = 0; i < MAXC; i++) begin
      exp_en[i] = 0; exp_valid[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_beat[i] = 0;
    end
    for (int f = 0; f < f_run; f++) begin
      for (int s = 0; s < M; s++) begin
        c0 = 1 + f * period + s;
        exp_en[c0]        = 1;
        exp_valid[c0 + 1] = 1;
        exp_beat[c0 + 1]  = f * M + s;
      end
    end
    if (f_run == 0) begin
      done_c = 1;
    end else begin
      last_c = (f_run - 1) * period + M;
      done_c = last_c + geff + 2;
    end
    exp_done[done_c] = 1;
    for (int i = 1; i <= done_c; i++) exp_busy[i] = 1;
    run_len = done_c + 3;

    restart_c = (do_restart && f_run > 0) ? int'($urandom_range(2, done_c - 1)) : -1;
    nchange_c = int'($urandom_range(1, run_len - 1));
    obs_en = 0; obs_valid = 0; obs_sof = 0; obs_eof = 0; obs_busy = 0;
    obs_done_cyc = -1; obs_max_frame = -1;

    @(posedge clk); #1;
    n_frames = NW'(n);
`ifdef SEQ_GAP_EN
    gap_cycles = 8'(g);
`endif
    start    = 1'b1;
    stop_req = (stop_c == 0);
    cyc      = 0;
    checking = 1'b1;
    for (int c = 1; c < run_len; c++) begin
      @(posedge clk); #1;
      cyc      = c;
      start    = (c == restart_c);
      stop_req = (c == stop_c);
      if (c == nchange_c) begin
        n_frames = NW'($urandom);
`ifdef SEQ_GAP_EN
        gap_cycles = 8'($urandom);
`endif
      end
      if (c == abort_c) begin
        checking = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_output("abort_src_enable", 32'(src_enable), 0);
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_done", 32'(done), 0);
        check_output("abort_sample_idx", 32'(sample_idx), 0);
        check_output("abort_frame_idx", 32'(frame_idx), 0);
        check_output("abort_sof", 32'(sof), 0);
        check_output("abort_eof", 32'(eof), 0);
        start = 1'b0; stop_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    checking = 1'b0;
    start    = 1'b0;
    stop_req = 1'b0;
  endtask

  initial begin
    int n, g, s;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_src_enable", 32'(src_enable), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_done", 32'(done), 0);
    check_output("reset_sample_idx", 32'(sample_idx), 0);
    check_output("reset_frame_idx", 32'(frame_idx), 0);
    check_output("reset_sof", 32'(sof), 0);
    check_output("reset_eof", 32'(eof), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] three back-to-back frames");
    apply_stimulus(3, 0, -1, 1'b0, -1);
    check_output("three_enables", obs_en, 96);
    check_output("three_valids", obs_valid, 96);
    check_output("three_sof", obs_sof, 3);
    check_output("three_eof", obs_eof, 3);
    check_output("three_done_cycle", obs_done_cyc, 98);

    $display("[TB] zero frames");
    apply_stimulus(0, 0, -1, 1'b0, -1);
    check_output("zero_enables", obs_en, 0);
    check_output("zero_busy_cycles", obs_busy, 1);
    check_output("zero_done_cycle", obs_done_cyc, 1);

    $display("[TB] stop at valid beat 40 of 5 frames");
    apply_stimulus(5, 0, 42, 1'b0, -1);
    check_output("stop_enables", obs_en, 64);
    check_output("stop_max_frame", obs_max_frame, 1);
    check_output("stop_done_cycle", obs_done_cyc, 66);

    $display("[TB] stop together with start");
    apply_stimulus(4, 0, 0, 1'b0, -1);
    check_output("stop_at_start_enables", obs_en, 32);

    $display("[TB] start and n_frames disturbed mid-run");
    apply_stimulus(3, 0, -1, 1'b1, -1);
    check_output("disturb_enables", obs_en, 96);
    check_output("disturb_done_cycle", obs_done_cyc, 98);

`ifdef SEQ_GAP_EN
    $display("[TB] two frames with 4-cycle gaps");
    apply_stimulus(2, 4, -1, 1'b0, -1);
    check_output("gap_enables", obs_en, 64);
    check_output("gap_valids", obs_valid, 64);
    check_output("gap_done_cycle", obs_done_cyc, 74);
`endif

    $display("[TB] reset at valid beat 17, then one frame");
    apply_stimulus(3, 0, -1, 1'b0, 19);
    apply_stimulus(1, 0, -1, 1'b0, -1);
    check_output("after_reset_enables", obs_en, 32);
    check_output("after_reset_sof", obs_sof, 1);

    $display("[TB] randomized runs");
    for (int i = 0; i < 10; i++) begin
      n = int'($urandom_range(0, 4));
      g = int'($urandom_range(0, 6));
      s = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, n * (M + g) + 4));
      apply_stimulus(n, g, s, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
